// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: op encodings, FSM states and flag bit positions.
// The optional multiplier is controlled by the ALU_SEQ_MUL_EN macro in the files that use this package.
package alu_seq_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2
    } state_e;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic [3:0] pack_flags(input logic z, input logic n,
                                              input logic c, input logic v);
        logic [3:0] f;
        f         = '0;
        f[FLAG_Z] = z;
        f[FLAG_N] = n;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add multiplier, one multiplier bit per cycle, LSB first.
// done_o and product_o are combinational during the last step so the caller can capture on that edge.
module alu_seq_mul #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 go_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   product_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic                 active_q;
    logic [CW-1:0]        cnt_q;
    logic [2*WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]     mplier_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   partial;

    always_comb begin
        partial   = mplier_q[0] ? mcand_q : '0;
        product_o = acc_q + partial;
        done_o    = active_q && (cnt_q == LAST);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else if (go_i) begin
            active_q <= 1'b1;
            cnt_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, a_i};
            mplier_q <= b_i;
            acc_q    <= '0;
        end else if (active_q) begin
            acc_q    <= product_o;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (done_o) begin
                active_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: A/B/G registers, flags, start/busy/done handshake.
// Define ALU_SEQ_MUL_EN to build the multi-cycle multiplier; otherwise op=111 is an illegal-op marker.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] buswires,
    input  logic             ain,
    input  logic             start,
    input  logic [2:0]       op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] aluout,
    output logic [3:0]       flags,
    output state_e           dbg_state
);

    localparam int SW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] g_q, g_d;
    logic [3:0]       flags_q, flags_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   diff_w;
    logic [WIDTH-1:0] res;
    logic             res_c;
    logic             res_v;
    logic [3:0]       exec_flags;

`ifdef ALU_SEQ_MUL_EN
    logic               mul_go;
    logic               mul_done;
    logic [WIDTH-1:0]   mul_a;
    logic [2*WIDTH-1:0] mul_product;
    logic [WIDTH-1:0]   mul_lo;

    // A simultaneous ain loads A from the bus on the start edge, so feed that value straight in.
    assign mul_a  = ain ? buswires : a_q;
    assign mul_lo = mul_product[WIDTH-1:0];

    alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .resetn    (resetn),
        .go_i      (mul_go),
        .a_i       (mul_a),
        .b_i       (buswires),
        .done_o    (mul_done),
        .product_o (mul_product)
    );
`endif

    always_comb begin
        sum_w  = {1'b0, a_q} + {1'b0, b_q};
        diff_w = {1'b0, a_q} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, 1'b1};
        res    = g_q;
        res_c  = 1'b0;
        res_v  = 1'b0;
        case (op_q)
            OP_ADD: begin
                res   = sum_w[WIDTH-1:0];
                res_c = sum_w[WIDTH];
                res_v = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                res   = diff_w[WIDTH-1:0];
                res_c = diff_w[WIDTH];
                res_v = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_AND: res = a_q & b_q;
            OP_OR:  res = a_q | b_q;
            OP_XOR: res = a_q ^ b_q;
            OP_SHL: res = a_q << b_q[SW-1:0];
            OP_SHR: res = a_q >> b_q[SW-1:0];
            default: begin
                // Reached only for op=111 without the multiplier: keep G, mark illegal via V.
                res   = g_q;
                res_v = 1'b1;
            end
        endcase
        exec_flags = pack_flags(res == '0, res[WIDTH-1], res_c, res_v);
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        g_d     = g_q;
        flags_d = flags_q;
        done_d  = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        mul_go  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (ain) begin
                    a_d = buswires;
                end
                if (start) begin
                    b_d  = buswires;
                    op_d = op;
`ifdef ALU_SEQ_MUL_EN
                    if (op == OP_MUL) begin
                        state_d = S_MUL;
                        mul_go  = 1'b1;
                    end else begin
                        state_d = S_EXEC;
                    end
`else
                    state_d = S_EXEC;
`endif
                end
            end
            S_EXEC: begin
                g_d     = res;
                flags_d = exec_flags;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            S_MUL: begin
`ifdef ALU_SEQ_MUL_EN
                if (mul_done) begin
                    g_d     = mul_lo;
                    flags_d = pack_flags(mul_lo == '0, mul_lo[WIDTH-1],
                                         |mul_product[2*WIDTH-1:WIDTH], 1'b0);
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
`else
                state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_ADD;
            g_q     <= '0;
            flags_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            g_q     <= g_d;
            flags_q <= flags_d;
            done_q  <= done_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign aluout    = g_q;
    assign flags     = flags_q;
    assign dbg_state = state_q;

endmodule
